// File: rtl/full_handshake_tx.sv
// Transmit side of a four-phase req/ack clock-domain-crossing link.
// Holds one pending word plus the registered request word; ack_i is double-flopped before use.
module full_handshake_tx #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_valid_i,
  input  logic [DW-1:0] tx_data_i,
  output logic          tx_ready_o,
  input  logic          ack_i,
  output logic          req_o,
  output logic [DW-1:0] req_data_o,
  output logic          done_o,
  output logic          busy_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b001,
    S_ASSERT   = 3'b010,
    S_DEASSERT = 3'b100
  } state_t;

  state_t        state_q, state_d;
  logic          ack_d_q, ack_s_q;
  logic          pend_vld_q, pend_vld_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  logic          req_q, req_d;
  logic [DW-1:0] req_data_q, req_data_d;
  logic          done_q, done_d;
  logic          accept;

  // Handshake: a word moves when tx_valid_i && tx_ready_o at a rising edge;
  // tx_ready_o depends only on the pending-buffer register.
  assign accept = tx_valid_i && !pend_vld_q;

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    req_d       = req_q;
    req_data_d  = req_data_q;
    done_d      = 1'b0;

    if (accept) begin
      pend_vld_d  = 1'b1;
      pend_data_d = tx_data_i;
    end

    case (state_q)
      S_IDLE: begin
        req_d = 1'b0;
        if (!ack_s_q && pend_vld_q) begin
          req_data_d = pend_data_q;
          pend_vld_d = 1'b0;
          req_d      = 1'b1;
          state_d    = S_ASSERT;
        end else if (!ack_s_q && accept) begin
          // Empty buffer: the new word bypasses straight to the output register.
          req_data_d = tx_data_i;
          pend_vld_d = 1'b0;
          req_d      = 1'b1;
          state_d    = S_ASSERT;
        end
      end
      S_ASSERT: begin
        req_d = 1'b1;
        if (ack_s_q) begin
          req_d   = 1'b0;
          state_d = S_DEASSERT;
        end
      end
      S_DEASSERT: begin
        req_d = 1'b0;
        if (!ack_s_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ack_d_q     <= 1'b0;
      ack_s_q     <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      req_q       <= 1'b0;
      req_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_d_q     <= ack_i;
      ack_s_q     <= ack_d_q;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      req_q       <= req_d;
      req_data_q  <= req_data_d;
      done_q      <= done_d;
    end
  end

  assign tx_ready_o = !pend_vld_q;
  assign req_o      = req_q;
  assign req_data_o = req_data_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_full_handshake_tx.sv
// Bench for full_handshake_tx: directed scenarios plus an asynchronous RX responder,
// with an in-order expected queue checked at every request launch.
`timescale 1ns/1ps
module tb_full_handshake_tx;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rx_clk = 1'b0;
  logic          rst;
  logic          tx_valid_i;
  logic [DW-1:0] tx_data_i;
  logic          tx_ready_o;
  logic          ack_i;
  logic          req_o;
  logic [DW-1:0] req_data_o;
  logic          done_o;
  logic          busy_o;

  logic          ack_man;
  logic          rx_auto;
  logic          ack_auto = 1'b0;
  logic          rx_s1 = 1'b0, rx_s2 = 1'b0;

  int            tests_run = 0;
  int            tests_failed = 0;
  int            done_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  logic [DW-1:0] last_launch = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always #7.15 rx_clk = ~rx_clk;

  assign ack_i = rx_auto ? ack_auto : ack_man;

  full_handshake_tx #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
    .ack_i(ack_i), .req_o(req_o), .req_data_o(req_data_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / monitor ----------------
  logic          rst_e = 1'b1;
  logic          req_prev = 1'b0, busy_prev = 1'b0, done_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;

  always @(posedge clk) rst_e <= rst;

  always @(negedge clk) begin
    if (!rst_e) begin
      if (req_o && !req_prev) begin
        last_launch = req_data_o;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL launch_unexpected: req_data_o=%h launched, expected queue empty", req_data_o);
        end else begin
          mon_exp = exp_q.pop_front();
          if (req_data_o !== mon_exp) begin
            tests_failed++;
            $display("FAIL launch_order: req_data_o=%h expected %h", req_data_o, mon_exp);
          end
        end
        tests_run++;
        if (busy_prev !== 1'b0) begin
          tests_failed++;
          $display("FAIL idle_gap: busy_o before launch=%b expected 0", busy_prev);
        end
      end else if (req_data_o !== data_prev) begin
        tests_failed++;
        $display("FAIL data_stable: req_data_o changed %h -> %h without a launch", data_prev, req_data_o);
      end
      if (done_o) begin
        done_cnt++;
        tests_run++;
        if (done_prev !== 1'b0) begin
          tests_failed++;
          $display("FAIL done_width: done_o high %b on consecutive cycles, expected single pulse", done_prev);
        end
      end
    end
    req_prev  = req_o;
    busy_prev = busy_o;
    done_prev = done_o;
    data_prev = req_data_o;
  end

  // Asynchronous RX partner: captures on synchronised req rise, acks, releases on req fall.
  always @(posedge rx_clk) begin
    rx_s1 <= req_o;
    rx_s2 <= rx_s1;
    if (rx_auto) begin
      if (rx_s2 && !ack_auto) begin
        ack_auto <= 1'b1;
        tests_run++;
        if (req_data_o !== last_launch) begin
          tests_failed++;
          $display("FAIL rx_capture: rx saw %h expected %h", req_data_o, last_launch);
        end
      end else if (!rx_s2 && ack_auto) begin
        ack_auto <= 1'b0;
      end
    end else begin
      ack_auto <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Offers d until accepted; returns just after the accepting edge with tx_valid_i still high.
  task automatic send_word(input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    tx_valid_i = 1'b1;
    tx_data_i  = d;
    while (!tx_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready_o) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: tx_ready_o=%b expected 1 within 500 cycles (word %h)", tx_ready_o, d);
      tx_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(d);
  endtask

  task automatic ack_responder(input int words);
    int n;
    for (int w = 0; w < words; w++) begin
      n = 0;
      while (req_o !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      if (req_o !== 1'b1) begin
        tests_run++; tests_failed++;
        $display("FAIL resp_req_rise_timeout: req_o=%b expected 1", req_o);
        return;
      end
      repeat (3) @(negedge clk);
      ack_man = 1'b1;
      n = 0;
      while (req_o !== 1'b0 && n < 500) begin @(negedge clk); n++; end
      if (req_o !== 1'b0) begin
        tests_run++; tests_failed++;
        $display("FAIL resp_req_fall_timeout: req_o=%b expected 0", req_o);
        return;
      end
      repeat (2) @(negedge clk);
      ack_man = 1'b0;
    end
  endtask

  task automatic wait_done(input int target, input int d0);
    int n = 0;
    while ((done_cnt - d0) < target && n < 500) begin @(negedge clk); n++; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [DW+3:0] exp_v;
    exp_v = {1'b0, {DW{1'b0}}, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; tx_valid_i = 1'b1; tx_data_i = 32'hDEAD_BEEF; ack_man = 1'b1; rx_auto = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({req_o, req_data_o, done_o, busy_o, tx_ready_o} !== exp_v) begin
        tests_failed++;
        $display("FAIL reset_values: req=%b data=%h done=%b busy=%b ready=%b expected 0/0/0/0/1",
                 req_o, req_data_o, done_o, busy_o, tx_ready_o);
      end
    end
    rst = 1'b0; ack_man = 1'b0; tx_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (tx_ready_o !== 1'b1 || req_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b req=%b busy=%b expected 1/0/0", tx_ready_o, req_o, busy_o);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    logic          exp_b;
    int            d0;
    w  = 32'hA5A5_0001;
    d0 = done_cnt;
    send_word(w);
    @(negedge clk);
    tx_valid_i = 1'b0;
    tests_run++;
    if (req_o !== 1'b1 || req_data_o !== w) begin
      tests_failed++;
      $display("FAIL single_launch: req=%b data=%h expected 1/%h", req_o, req_data_o, w);
    end
    repeat (3) @(negedge clk);
    ack_man = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_b = (i == 2) ? 1'b0 : 1'b1;
      tests_run++;
      if (req_o !== exp_b || req_data_o !== w) begin
        tests_failed++;
        $display("FAIL single_req_fall[%0d]: req=%b data=%h expected %b/%h", i, req_o, req_data_o, exp_b, w);
      end
    end
    repeat (2) @(negedge clk);
    ack_man = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_b = (i == 2);
      tests_run++;
      if (done_o !== exp_b) begin
        tests_failed++;
        $display("FAIL single_done[%0d]: done_o=%b expected %b", i, done_o, exp_b);
      end
    end
    tests_run++;
    if (busy_o !== 1'b0 || req_data_o !== w || (done_cnt - d0) != 1) begin
      tests_failed++;
      $display("FAIL single_end: busy=%b data=%h dones=%0d expected 0/%h/1", busy_o, req_data_o, done_cnt - d0, w);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    fork
      begin
        send_word(32'h1);
        send_word(32'h2);
        @(negedge clk);
        tests_run++;
        if (tx_ready_o !== 1'b0 || req_data_o !== 32'h1) begin
          tests_failed++;
          $display("FAIL b2b_pending: ready=%b data=%h expected 0/00000001", tx_ready_o, req_data_o);
        end
        send_word(32'h3);
        @(negedge clk);
        tx_valid_i = 1'b0;
        tests_run++;
        if (req_data_o !== 32'h2 || tx_ready_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_stall: data=%h ready=%b expected 00000002/0", req_data_o, tx_ready_o);
        end
      end
      ack_responder(3);
    join
    wait_done(3, d0);
    repeat (3) @(negedge clk);
    tests_run++;
    if ((done_cnt - d0) != 3 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_count: dones=%0d pending_expected=%0d expected 3/0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_stale_ack();
    int            d0 = done_cnt;
    logic          exp_b;
    ack_man = 1'b1;
    repeat (3) @(negedge clk);
    send_word(32'h55);
    @(negedge clk);
    tx_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (req_o !== 1'b0 || tx_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_hold: req=%b ready=%b busy=%b expected 0/0/0", req_o, tx_ready_o, busy_o);
    end
    ack_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_b = (i == 2);
      tests_run++;
      if (req_o !== exp_b) begin
        tests_failed++;
        $display("FAIL stale_launch[%0d]: req_o=%b expected %b", i, req_o, exp_b);
      end
    end
    tests_run++;
    if (req_data_o !== 32'h55 || tx_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_data: data=%h ready=%b expected 00000055/1", req_data_o, tx_ready_o);
    end
    ack_responder(1);
    wait_done(1, d0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d0;
    int bad = 0;
    send_word(32'h11);
    send_word(32'h22);
    @(negedge clk);
    tx_valid_i = 1'b0;
    tests_run++;
    if (busy_o !== 1'b1 || req_o !== 1'b1 || tx_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_setup: busy=%b req=%b ready=%b expected 1/1/0", busy_o, req_o, tx_ready_o);
    end
    d0  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_o !== 1'b0 || busy_o !== 1'b0 || tx_ready_o !== 1'b1 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_abort: req=%b busy=%b ready=%b done=%b expected 0/0/1/0",
               req_o, busy_o, tx_ready_o, done_o);
    end
    exp_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req_o !== 1'b0 || done_o !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || (done_cnt - d0) != 0) begin
      tests_failed++;
      $display("FAIL midrst_discard: bad_cycles=%0d dones=%0d expected 0/0", bad, done_cnt - d0);
    end
  endtask

  task automatic test_random_cdc();
    int d0 = done_cnt;
    int g;
    int n = 0;
    rx_auto = 1'b1;
    for (int i = 0; i < 200; i++) begin
      g = $urandom_range(0, 3);
      if (g > 0) begin
        @(negedge clk);
        tx_valid_i = 1'b0;
        repeat (g - 1) @(negedge clk);
      end
      send_word($urandom);
    end
    @(negedge clk);
    tx_valid_i = 1'b0;
    while (((done_cnt - d0) < 200 || busy_o) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if ((done_cnt - d0) != 200 || exp_q.size() != 0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL random_cdc: dones=%0d left=%0d busy=%b expected 200/0/0", done_cnt - d0, exp_q.size(), busy_o);
    end
    rx_auto = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1; tx_valid_i = 1'b0; tx_data_i = '0; ack_man = 1'b0; rx_auto = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stale_ack();
    test_reset_mid();
    test_random_cdc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/full_handshake_tx.md
# full_handshake_tx

Transmit side of the four-phase (req/ack) clock-domain-crossing link. It accepts words from the local TX-domain producer over a valid/ready port and holds them in a one-entry pending buffer plus an output holding register. It drives `req_o`/`req_data_o` into the receiving domain and synchronises the returned `ack_i`. It is the upstream partner of the full-handshake receiver and completes one word per full req↑ ack↑ req↓ ack↓ cycle.

## Interface
- `DW`, default 32: width of a transferred word.

- `clk`  in  1  TX-domain clock.
- `rst`  in  1  synchronous, active-high reset.
- `tx_valid_i`  in  1  local producer offers `tx_data_i` this cycle.
- `tx_data_i`  in  DW  local word to send.
- `tx_ready_o`  out  1  pending buffer free; the word is accepted when `tx_valid_i && tx_ready_o` at a rising edge.
- `ack_i`  in  1  acknowledge from the RX domain (asynchronous).
- `req_o`  out  1  request to the RX domain (registered).
- `req_data_o`  out  DW  word presented to the RX domain (registered).
- `done_o`  out  1  one-cycle pulse: a transfer fully completed (ack returned low).
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- Reset values: `req_o`=0, `req_data_o`=0, `done_o`=0, `busy_o`=0, `tx_ready_o`=1. The pending buffer is empty, both ack sync flops are 0 and the state is IDLE. Reset mid-transfer aborts the transfer and drops `req_o` on the next edge; the pending word is discarded.
- `ack_i` passes through two flops (`ack_d` → `ack_s`). The FSM uses only `ack_s`.
- Pending buffer: one entry (`pend_vld`, `pend_data`). `tx_ready_o` = !`pend_vld`, derived from a register with no combinational path from `tx_valid_i`. An accepted word goes to the pending buffer unless it bypasses it (IDLE rule below).
- State IDLE (one-hot 3'b001):
  - Launch condition: `ack_s`=0 and a word is available.
  - If `pend_vld`=1, load `pend_data` into `req_data_o`, clear `pend_vld`, set `req_o`=1 and go to ASSERT.
  - Else, if a word is accepted this cycle, load `tx_data_i` directly into `req_data_o`, leave `pend_vld`=0, set `req_o`=1 and go to ASSERT.
  - If `ack_s`=1 (stale or spurious ack), stay in IDLE. A word accepted this cycle goes into the pending buffer.
- State ASSERT (3'b010): `req_o`=1. When `ack_s`=1, clear `req_o` and go to DEASSERT.
- State DEASSERT (3'b100): `req_o`=0. When `ack_s`=0, go to IDLE and pulse `done_o`=1 for exactly one cycle.
- Illegal state codes go to IDLE with `req_o`=0.
- `req_data_o` changes only on the IDLE→ASSERT edge. It is stable for the whole req/ack cycle and afterwards until the next launch.
- In ASSERT and DEASSERT, a word is accepted into the pending buffer if `tx_ready_o`=1. Accepted words are never dropped or reordered.

## Timing
- Launch: a word accepted at edge N from IDLE with the buffer empty and `ack_s`=0 gives `req_o`=1 and valid `req_data_o` after edge N.
- Ack rise: `ack_i` first sampled high at edge E gives `ack_s`=1 after E+1 and `req_o`=0 after E+2.
- Ack fall: `ack_i` first sampled low at edge F gives state IDLE and `done_o`=1 after F+2. The next launch from the pending buffer has `req_o`=1 after F+3, so `req_o` is low for at least one full cycle in IDLE between transfers.
- Pending drain: `tx_ready_o` rises the cycle after the pending word is launched. There is no same-cycle refill.
- Max throughput: one word per handshake round trip, which is at least 6 TX cycles plus the RX latency.

## Test plan
- Reset behaviour: hold `rst`=1 for 3 cycles with `tx_valid_i`=1 and `ack_i`=1 → all outputs stay at reset values and nothing is accepted. Release reset with `ack_i`=0 → `tx_ready_o`=1.
- Single transfer: send 0xA5A5_0001 with the model RX acking 4 cycles after `req_o`↑ and dropping ack 3 cycles after `req_o`↓.
  - `req_o` rises 1 cycle after acceptance.
  - `req_o` falls 3 edges after ack↑.
  - `done_o` is one pulse 3 edges after ack↓.
  - `req_data_o` stays stable throughout.
- Back-to-back: offer 0x1, 0x2, 0x3 continuously.
  - 0x1 bypasses to `req_data_o`.
  - 0x2 is held pending and `tx_ready_o`=0 while it waits.
  - 0x3 is stalled until 0x2 launches.
  - RX receives 0x1, 0x2, 0x3 in order, `done_o` pulses exactly 3 times, and `req_o` is low for ≥1 IDLE cycle between words.
- Stale ack: hold `ack_i`=1 in IDLE, then offer 0x55 → no launch while `ack_s`=1 and 0x55 sits pending. Drop `ack_i` → `req_o` rises 3 edges later carrying 0x55.
- Reset mid-transfer: assert `rst` during ASSERT with one word pending → after the next edge `req_o`=0, state is IDLE, `tx_ready_o`=1 and no `done_o` pulse occurs.
- Random CDC: run RX at an asynchronous clock ratio (e.g. 37:53) with 200 random words → scoreboard matches in order, `req_data_o` never changes while `req_o`=1 or the synchronised ack is high, and there are no protocol violations.
